// File: rtl/tensor_alu_seq.sv
// ============================================================================
// Module      : tensor_alu_seq
// Description : Command sequencer that streams scratchpad operands through the
//               element ALU and writes each result back one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_alu_seq #(
   parameter int AW    = 10,
   parameter int LEN_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             io_cmd_valid,
   output logic             io_cmd_ready,
   input  logic [2:0]       io_cmd_opcode,
   input  logic [LEN_W-1:0] io_cmd_len,
   input  logic [AW-1:0]    io_cmd_dst,
   input  logic [AW-1:0]    io_cmd_src,
   input  logic             io_cmd_use_imm,
   input  logic [31:0]      io_cmd_imm,
   output logic             io_rd_en,
   output logic [AW-1:0]    io_rd_addr_a,
   output logic [AW-1:0]    io_rd_addr_b,
   input  logic [31:0]      io_rd_data_a,
   input  logic [31:0]      io_rd_data_b,
   output logic [2:0]       io_alu_opcode,
   output logic [31:0]      io_alu_a,
   output logic [31:0]      io_alu_b,
   input  logic [31:0]      io_alu_y,
   output logic             io_wr_en,
   output logic [AW-1:0]    io_wr_addr,
   output logic [31:0]      io_wr_data,
   output logic             io_busy,
   output logic             io_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [2:0]       r_op;
   logic             r_use_imm;
   logic [31:0]      r_imm;
   logic [LEN_W-1:0] r_remain;
   logic [AW-1:0]    r_addr_a;
   logic [AW-1:0]    r_addr_b;
   logic             r_wr_valid;
   logic [AW-1:0]    r_wr_addr;

   logic             w_accept;
   logic             w_last;

   assign w_accept = io_cmd_valid && (r_state == S_IDLE);
   assign w_last   = (r_remain == LEN_W'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      io_cmd_ready = 1'b0;
      io_busy      = 1'b1;
      io_done      = 1'b0;
      io_rd_en     = 1'b0;
      case (r_state)
         S_IDLE: begin
            io_cmd_ready = 1'b1;
            io_busy      = 1'b0;
            if (io_cmd_valid) begin
               w_state_nxt = (io_cmd_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            io_rd_en = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            io_done     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Read stage walks the two address streams; the write stage trails it by
   // exactly one cycle so the scratchpad read data lines up with wr_addr.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_op       <= '0;
         r_use_imm  <= 1'b0;
         r_imm      <= '0;
         r_remain   <= '0;
         r_addr_a   <= '0;
         r_addr_b   <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
      end else begin
         if (w_accept) begin
            r_op      <= io_cmd_opcode;
            r_use_imm <= io_cmd_use_imm;
            r_imm     <= io_cmd_imm;
            r_remain  <= io_cmd_len;
            r_addr_a  <= io_cmd_dst;
            r_addr_b  <= io_cmd_src;
         end else if (io_rd_en) begin
            r_remain  <= r_remain - LEN_W'(1);
            r_addr_a  <= r_addr_a + AW'(1);
            r_addr_b  <= r_addr_b + AW'(1);
         end
         r_wr_valid <= io_rd_en;
         if (io_rd_en) begin
            r_wr_addr <= r_addr_a;
         end
      end
   end

   assign io_rd_addr_a  = r_addr_a;
   assign io_rd_addr_b  = r_addr_b;
   assign io_wr_en      = r_wr_valid;
   assign io_wr_addr    = r_wr_addr;
   assign io_alu_opcode = (r_state == S_IDLE) ? 3'd0 : r_op;
   assign io_alu_a      = r_wr_valid ? io_rd_data_a : 32'd0;
   assign io_alu_b      = r_wr_valid ? (r_use_imm ? r_imm : io_rd_data_b) : 32'd0;
   assign io_wr_data    = io_alu_y;

endmodule

`default_nettype wire

// File: tb/tb_tensor_alu_seq.sv
// ============================================================================
// Module      : tb_tensor_alu_seq
// Description : Directed bench for tensor_alu_seq with scratchpad and ALU models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tensor_alu_seq;

   logic        clock;
   logic        reset_n;
   logic        io_cmd_valid;
   logic        io_cmd_ready;
   logic [2:0]  io_cmd_opcode;
   logic [15:0] io_cmd_len;
   logic [9:0]  io_cmd_dst;
   logic [9:0]  io_cmd_src;
   logic        io_cmd_use_imm;
   logic [31:0] io_cmd_imm;
   logic        io_rd_en;
   logic [9:0]  io_rd_addr_a;
   logic [9:0]  io_rd_addr_b;
   logic [31:0] io_rd_data_a;
   logic [31:0] io_rd_data_b;
   logic [2:0]  io_alu_opcode;
   logic [31:0] io_alu_a;
   logic [31:0] io_alu_b;
   logic [31:0] io_alu_y;
   logic        io_wr_en;
   logic [9:0]  io_wr_addr;
   logic [31:0] io_wr_data;
   logic        io_busy;
   logic        io_done;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:1023];
   logic        tb_we;
   logic [9:0]  tb_addr;
   logic [31:0] tb_data;
   logic [31:0] neg_b;

   tensor_alu_seq #(.AW(10), .LEN_W(16)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .io_cmd_valid   (io_cmd_valid),
      .io_cmd_ready   (io_cmd_ready),
      .io_cmd_opcode  (io_cmd_opcode),
      .io_cmd_len     (io_cmd_len),
      .io_cmd_dst     (io_cmd_dst),
      .io_cmd_src     (io_cmd_src),
      .io_cmd_use_imm (io_cmd_use_imm),
      .io_cmd_imm     (io_cmd_imm),
      .io_rd_en       (io_rd_en),
      .io_rd_addr_a   (io_rd_addr_a),
      .io_rd_addr_b   (io_rd_addr_b),
      .io_rd_data_a   (io_rd_data_a),
      .io_rd_data_b   (io_rd_data_b),
      .io_alu_opcode  (io_alu_opcode),
      .io_alu_a       (io_alu_a),
      .io_alu_b       (io_alu_b),
      .io_alu_y       (io_alu_y),
      .io_wr_en       (io_wr_en),
      .io_wr_addr     (io_wr_addr),
      .io_wr_data     (io_wr_data),
      .io_busy        (io_busy),
      .io_done        (io_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scratchpad: one-cycle read latency, read-old-data on same-address write.
   always @(posedge clock) begin
      if (io_rd_en) begin
         io_rd_data_a <= mem[io_rd_addr_a];
         io_rd_data_b <= mem[io_rd_addr_b];
      end
      if (io_wr_en) begin
         mem[io_wr_addr] <= io_wr_data;
      end else if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end
   end

   always_comb begin
      neg_b = 32'd0 - io_alu_b;
      case (io_alu_opcode)
         3'd0:    io_alu_y = ($signed(io_alu_a) < $signed(io_alu_b)) ? io_alu_a : io_alu_b;
         3'd1:    io_alu_y = ($signed(io_alu_a) > $signed(io_alu_b)) ? io_alu_a : io_alu_b;
         3'd2:    io_alu_y = io_alu_a + io_alu_b;
         3'd3:    io_alu_y = $unsigned($signed(io_alu_a) >>> io_alu_b[4:0]);
         3'd4:    io_alu_y = io_alu_a << neg_b[4:0];
         default: io_alu_y = io_alu_a;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      tb_we   = 1'b1;
      tb_addr = a;
      tb_data = d;
      step();
      tb_we   = 1'b0;
   endtask

   task automatic offer(input logic [2:0] op, input logic [15:0] len, input logic [9:0] dst,
                        input logic [9:0] src, input logic use_imm, input logic [31:0] imm);
      io_cmd_valid   = 1'b1;
      io_cmd_opcode  = op;
      io_cmd_len     = len;
      io_cmd_dst     = dst;
      io_cmd_src     = src;
      io_cmd_use_imm = use_imm;
      io_cmd_imm     = imm;
   endtask

   logic [31:0] exp_add [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
   logic [9:0]  wrap_a  [3] = '{10'd1022, 10'd1023, 10'd0};
   logic [9:0]  wrap_b  [3] = '{10'd0, 10'd1, 10'd2};
   logic [31:0] wrap_d  [3] = '{32'd7, 32'd100, 32'd7};

   initial begin
      reset_n      = 1'b0;
      tb_we        = 1'b0;
      tb_addr      = '0;
      tb_data      = '0;
      io_cmd_valid = 1'b0;
      offer(3'd0, 16'd0, 10'd0, 10'd0, 1'b0, 32'd0);
      io_cmd_valid = 1'b0;
      step();
      step();
      chkb("rst_ready", io_cmd_ready, 1'b1);
      chkb("rst_busy",  io_busy,      1'b0);
      chkb("rst_done",  io_done,      1'b0);
      chkb("rst_rd_en", io_rd_en,     1'b0);
      chkb("rst_wr_en", io_wr_en,     1'b0);
      chk ("rst_alu_op", 32'(io_alu_opcode), 32'd0);
      reset_n = 1'b1;
      step();

      // Vector add from two streams
      for (int k = 0; k < 4; k++) begin
         poke(10'(8 + k), 32'(k + 1));
         poke(10'(20 + k), 32'((k + 1) * 10));
      end
      offer(3'd2, 16'd4, 10'd8, 10'd20, 1'b0, 32'd0);
      chkb("add_ready_T", io_cmd_ready, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         io_cmd_valid = 1'b0;
         chkb("add_rd_en", io_rd_en, (i < 4));
         chkb("add_wr_en", io_wr_en, (i >= 1));
         chkb("add_busy",  io_busy,  1'b1);
         if (i < 4) begin
            chk("add_rd_a", 32'(io_rd_addr_a), 32'(8 + i));
            chk("add_rd_b", 32'(io_rd_addr_b), 32'(20 + i));
            chk("add_alu_op", 32'(io_alu_opcode), 32'd2);
         end
         if (i >= 1) begin
            chk("add_wr_addr", 32'(io_wr_addr), 32'(8 + i - 1));
            chk("add_wr_data", io_wr_data, exp_add[i - 1]);
         end
      end
      step();
      chkb("add_done",  io_done,      1'b1);
      chkb("add_ready_done", io_cmd_ready, 1'b0);
      chkb("add_busy_done",  io_busy, 1'b1);
      chk ("add_alu_a_idle", io_alu_a, 32'd0);
      chk ("add_alu_b_idle", io_alu_b, 32'd0);
      step();
      chkb("add_ready_after", io_cmd_ready, 1'b1);
      chkb("add_done_after",  io_done,      1'b0);
      chk ("add_alu_op_idle", 32'(io_alu_opcode), 32'd0);
      for (int k = 0; k < 4; k++) chk("add_mem", mem[8 + k], exp_add[k]);

      // Immediate arithmetic shift right, then signed min
      poke(10'd0, 32'hFFFF_FF00);
      offer(3'd3, 16'd1, 10'd0, 10'd5, 1'b1, 32'd4);
      step();
      io_cmd_valid = 1'b0;
      chkb("shr_rd_en", io_rd_en, 1'b1);
      chk ("shr_rd_a", 32'(io_rd_addr_a), 32'd0);
      step();
      chkb("shr_wr_en", io_wr_en, 1'b1);
      chk ("shr_alu_b", io_alu_b, 32'd4);
      chk ("shr_wr_data", io_wr_data, 32'hFFFF_FFF0);
      step();
      chkb("shr_done", io_done, 1'b1);
      step();
      chk ("shr_mem", mem[0], 32'hFFFF_FFF0);
      offer(3'd0, 16'd1, 10'd0, 10'd5, 1'b1, 32'hFFFF_FFF8);
      step();
      io_cmd_valid = 1'b0;
      step();
      chk ("min_alu_op", 32'(io_alu_opcode), 32'd0);
      chk ("min_wr_data", io_wr_data, 32'hFFFF_FFF0);
      step();
      step();
      chk ("min_mem", mem[0], 32'hFFFF_FFF0);

      // Zero-length command
      offer(3'd2, 16'd0, 10'd50, 10'd60, 1'b0, 32'd0);
      step();
      io_cmd_valid = 1'b0;
      chkb("len0_done",  io_done,      1'b1);
      chkb("len0_busy",  io_busy,      1'b1);
      chkb("len0_ready", io_cmd_ready, 1'b0);
      chkb("len0_rd_en", io_rd_en,     1'b0);
      chkb("len0_wr_en", io_wr_en,     1'b0);
      step();
      chkb("len0_ready_after", io_cmd_ready, 1'b1);
      chkb("len0_busy_after",  io_busy,      1'b0);
      chkb("len0_done_after",  io_done,      1'b0);
      chkb("len0_wr_after",    io_wr_en,     1'b0);

      // Address wrap-around with max
      poke(10'd1022, 32'd5);
      poke(10'd1023, 32'd100);
      poke(10'd0, 32'd7);
      poke(10'd1, 32'd50);
      poke(10'd2, 32'd1);
      offer(3'd1, 16'd3, 10'd1022, 10'd0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         io_cmd_valid = 1'b0;
         chkb("wrap_rd_en", io_rd_en, (i < 3));
         chkb("wrap_wr_en", io_wr_en, (i >= 1));
         if (i < 3) begin
            chk("wrap_rd_a", 32'(io_rd_addr_a), 32'(wrap_a[i]));
            chk("wrap_rd_b", 32'(io_rd_addr_b), 32'(wrap_b[i]));
         end
         if (i >= 1) begin
            chk("wrap_wr_addr", 32'(io_wr_addr), 32'(wrap_a[i - 1]));
            chk("wrap_wr_data", io_wr_data, wrap_d[i - 1]);
         end
      end
      step();
      chkb("wrap_done", io_done, 1'b1);
      step();
      for (int k = 0; k < 3; k++) chk("wrap_mem", mem[wrap_a[k]], wrap_d[k]);

      // Reset asserted mid-command
      for (int k = 0; k < 8; k++) begin
         poke(10'(100 + k), 32'hAAAA_0000 + 32'(k));
         poke(10'(200 + k), 32'(k + 1));
      end
      offer(3'd2, 16'd8, 10'd100, 10'd200, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         io_cmd_valid = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      chkb("mrst_rd_en", io_rd_en,     1'b0);
      chkb("mrst_wr_en", io_wr_en,     1'b0);
      chkb("mrst_busy",  io_busy,      1'b0);
      chkb("mrst_done",  io_done,      1'b0);
      chkb("mrst_ready", io_cmd_ready, 1'b1);
      chk ("mrst_alu_a", io_alu_a,     32'd0);
      chk ("mrst_alu_op", 32'(io_alu_opcode), 32'd0);
      step();
      step();
      chkb("mrst_ready_hold", io_cmd_ready, 1'b1);
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chkb("mrst_no_done", io_done, 1'b0);
         chkb("mrst_no_wr",   io_wr_en, 1'b0);
      end
      chk("mrst_mem0", mem[100], 32'hAAAA_0001);
      chk("mrst_mem1", mem[101], 32'hAAAA_0003);
      for (int k = 2; k < 8; k++) chk("mrst_mem_untouched", mem[100 + k], 32'hAAAA_0000 + 32'(k));

      // Back-to-back: second command held valid while the first runs
      poke(10'd300, 32'd1);
      poke(10'd301, 32'd2);
      poke(10'd310, 32'd10);
      poke(10'd311, 32'd20);
      poke(10'd400, 32'h1234_5678);
      offer(3'd2, 16'd2, 10'd300, 10'd310, 1'b0, 32'd0);
      step();
      offer(3'd5, 16'd1, 10'd400, 10'd410, 1'b0, 32'd0);
      chkb("b2b_ready_1", io_cmd_ready, 1'b0);
      chk ("b2b_rd_a_1", 32'(io_rd_addr_a), 32'd300);
      step();
      chkb("b2b_ready_2", io_cmd_ready, 1'b0);
      chk ("b2b_wr_data_0", io_wr_data, 32'd11);
      step();
      chk ("b2b_alu_op", 32'(io_alu_opcode), 32'd2);
      chk ("b2b_wr_addr_1", 32'(io_wr_addr), 32'd301);
      chk ("b2b_wr_data_1", io_wr_data, 32'd22);
      step();
      chkb("b2b_done_a",  io_done,      1'b1);
      chkb("b2b_ready_4", io_cmd_ready, 1'b0);
      chkb("b2b_wr_en_4", io_wr_en,     1'b0);
      step();
      chkb("b2b_ready_5", io_cmd_ready, 1'b1);
      step();
      io_cmd_valid = 1'b0;
      chkb("b2b_rd_en_b", io_rd_en, 1'b1);
      chk ("b2b_rd_a_b", 32'(io_rd_addr_a), 32'd400);
      chk ("b2b_alu_op_b", 32'(io_alu_opcode), 32'd5);
      step();
      chkb("b2b_wr_en_b", io_wr_en, 1'b1);
      chk ("b2b_wr_addr_b", 32'(io_wr_addr), 32'd400);
      chk ("b2b_wr_data_b", io_wr_data, 32'h1234_5678);
      step();
      chkb("b2b_done_b", io_done, 1'b1);
      step();
      chkb("b2b_idle", io_busy, 1'b0);
      chk ("b2b_mem300", mem[300], 32'd11);
      chk ("b2b_mem301", mem[301], 32'd22);
      chk ("b2b_mem400", mem[400], 32'h1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tensor_alu_seq.md
Name: tensor_alu_seq

Overview:
- Command-driven sequencer for the 32-bit element ALU (min/max/add/shr/shl-by-negated-shift).
- Accepts one vector command, streams operand reads from the accumulator scratchpad, and drives the ALU.
- Writes results back to the scratchpad. Sits between the compute-module instruction decoder and the scratchpad/ALU datapath.

Parameters:
- AW, 10, scratchpad address width in elements; all address arithmetic wraps modulo 2^AW.
- LEN_W, 16, width of the element-count field.

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_cmd_valid  in  1  command offered
- io_cmd_ready  out  1  high only in IDLE
- io_cmd_opcode  in  3  ALU opcode: 0 min, 1 max, 2 add, 3 shr, 4 shl, 5-7 pass a
- io_cmd_len  in  LEN_W  number of elements
- io_cmd_dst  in  AW  base address of operand a and of the result
- io_cmd_src  in  AW  base address of operand b
- io_cmd_use_imm  in  1  operand b = imm instead of src data
- io_cmd_imm  in  32  immediate operand
- io_rd_en  out  1  scratchpad read strobe
- io_rd_addr_a  out  AW  read address, operand a
- io_rd_addr_b  out  AW  read address, operand b
- io_rd_data_a  in  32  read data a, valid exactly 1 cycle after io_rd_en
- io_rd_data_b  in  32  read data b, same timing
- io_alu_opcode  out  3  to ALU
- io_alu_a  out  32  to ALU
- io_alu_b  out  32  to ALU
- io_alu_y  in  32  ALU result, combinational
- io_wr_en  out  1  scratchpad write strobe
- io_wr_addr  out  AW  write address
- io_wr_data  out  32  write data, equal to io_alu_y
- io_busy  out  1  state != IDLE
- io_done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
- Reset (async, reset_n=0): state IDLE, all counters and registers 0; io_rd_en, io_wr_en, io_busy, io_done = 0; io_cmd_ready = 1.
- Accept on io_cmd_valid && io_cmd_ready in cycle T. opcode, len, dst, src, use_imm and imm are latched; they are held constant for the whole command and ignored thereafter.
- IDLE -> RUN if len > 0; IDLE -> DONE if len = 0 (no reads, no writes).
- RUN, element i = 0..len-1, in cycle T+1+i:
  - io_rd_en = 1
  - io_rd_addr_a = dst+i, io_rd_addr_b = src+i (mod 2^AW)
  - After issuing i = len-1: RUN -> DRAIN.
- Write stage, registered one cycle behind the read stage:
  - cycle T+2+i: io_wr_en = 1, io_wr_addr = dst+i
  - io_alu_a = io_rd_data_a
  - io_alu_b = use_imm ? imm : io_rd_data_b
  - io_wr_data = io_alu_y
- DRAIN, cycle T+len+1: final write, no read -> DONE.
- DONE: io_done = 1 for one cycle, io_cmd_ready = 0 -> IDLE.
  - len > 0: done at T+len+2, next accept possible at T+len+3.
  - len = 0: done at T+1, next accept possible at T+2.
- io_alu_opcode = latched opcode whenever busy, 0 in IDLE. io_alu_a/io_alu_b are 0 when io_wr_en = 0.
- Throughput: one element per cycle, no bubbles inside a command.
- Hazards: no forwarding. The scratchpad is read-old-data on a same-address read/write. Overlapping src/dst ranges with src = dst-1 therefore read pre-command values; this is defined behaviour, not an error.
- Wrap-around: dst+i and src+i wrap past 2^AW-1 to 0.
- io_cmd_valid while busy is ignored; it is not queued.
- Reset asserted mid-command: immediate return to IDLE. No further reads or writes, no done pulse. Writes already performed are not undone.
- Opcodes 5-7: elements are still read and written; the result equals a (copy-in-place).

Test Plan:
- Add, no imm: mem[8..11] = {1,2,3,4}, mem[20..23] = {10,20,30,40}, cmd op=2 len=4 dst=8 src=20 accepted at T -> rd_en at T+1..T+4; writes mem[8..11] = {11,22,33,44} at T+2..T+5; done at T+6; ready high at T+7.
- Imm shr/min: mem[0] = 0xFFFFFF00, op=3 use_imm imm=4 len=1 dst=0 -> mem[0] = 0xFFFFFFF0. Then op=0 imm=0xFFFFFFF8 -> mem[0] = 0xFFFFFFF0 (signed min).
- len=0: accept at T -> no rd_en/wr_en ever; done at T+1; busy high T+1 only; ready at T+2.
- Wrap (AW=10): dst=1022 src=0 len=3 op=1 -> writes to addresses 1022, 1023, 0 in order; read-b addresses 0, 1, 2.
- Reset mid-run: len=8, reset_n low at T+4 -> outputs 0 and ready 1 during reset; only addresses dst+0..dst+1 written; no done pulse.
- Back-to-back: second cmd held valid from T; accepted at T+len+3; io_cmd_valid during busy produces no effect and no extra writes.
